pe_row_db: RTL and testbench
============================

# pe_row_db

Double-buffered, weight-stationary systolic PE row; successor of the single-buffer PE row in the GEMV array. Each of `w_tile_column_size` PEs keeps an active weight for compute and a shadow weight that loads through the vertical weight chain. A load counter tracks when the shadow tile is full, so the next weight tile can be preloaded while the current one computes and then swapped in with a single-cycle command. Adds activation/sum valid tracking, compute stall, and optional saturating accumulation.

## Interface
- `data_width`, 22, activation/weight width, signed two's complement
- `w_tile_column_size`, 11, PEs (columns) in the row
- `w_tile_row_size`, 11, `w_en` shifts needed to fill the shadow tile of the whole array
- `acc_width`, 2*`data_width`, partial-sum width per column (≥ 2*`data_width`)
- `saturate`, 0, 0 = wrap modulo 2^`acc_width`, 1 = clamp to signed `acc_width` range
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `w_en`  in  1  shift the weight chain one row
- `w_swap`  in  1  copy shadow→active weights (honoured only when `w_ready`)
- `w_compute`  in  1  1 = advance compute pipeline, 0 = stall (hold)
- `w_ready`  out  1  shadow tile full
- `w_overrun`  out  1  sticky: `w_en` seen while full
- `act_valid_left`  in  1  `active_left` valid
- `active_left`  in  `data_width`  activation from left neighbour
- `act_valid_right`  out  1  valid for `active_right`
- `active_right`  out  `data_width`  activation to right neighbour
- `in_weight_above`  in  `data_width`*`w_tile_column_size`  weights from row above, column c at [c*dw +: dw]
- `out_weight_below`  out  `data_width`*`w_tile_column_size`  shadow weights to row below
- `in_sum`  in  `acc_width`*`w_tile_column_size`  partial sums from above
- `out_sum`  out  `acc_width`*`w_tile_column_size`  partial sums to below
- `out_sum_valid`  out  `w_tile_column_size`  per-column valid for `out_sum`

## Operation
- Per PE c: `shadow_w[c]`, `active_w[c]`, activation register `a_reg[c]`, valid register `v_reg[c]`, sum register `s_reg[c]`.
- PE c input: A_0 = `active_left` and V_0 = `act_valid_left`; for c>0, A_c = `a_reg[c-1]` and V_c = `v_reg[c-1]`.
- `w_en`=1: `shadow_w[c]` <= `in_weight_above[c]`; `out_weight_below[c]` = `shadow_w[c]`. Weight shifting is independent of `w_compute`.
- Load FSM:
  - EMPTY (count 0): `w_en` → LOADING with count 1 (→ FULL directly if `w_tile_row_size`=1).
  - LOADING: `w_en` increments count; reaching `w_tile_row_size` → FULL.
  - FULL: `w_ready`=1. `w_en` still shifts and sets `w_overrun`; count holds.
- `w_swap` when FULL: `active_w` <= `shadow_w` (pre-edge values), `w_overrun` cleared, FSM → EMPTY. If `w_en` is also high that cycle, the shift still occurs and FSM → LOADING with count 1.
- `w_swap` when not FULL: ignored; no state change.
- `w_compute`=1: `a_reg[c]` <= A_c, `v_reg[c]` <= V_c, `s_reg[c]` <= `in_sum[c]` + sext(A_c*`active_w[c]`).
- `w_compute`=0: all compute registers hold.
- `active_right`=`a_reg[N-1]`, `act_valid_right`=`v_reg[N-1]`, `out_sum[c]`=`s_reg[c]`, `out_sum_valid[c]`=`v_reg[c]`.
- Arithmetic: full-precision signed product sign-extended to `acc_width`, then `acc_width`+1-bit signed add. `saturate`=0: truncate. `saturate`=1: clamp to [-2^(acc_width-1), 2^(acc_width-1)-1].
- A swap in the same cycle as compute: the compute uses the pre-swap `active_w`.

## Timing
- Reset: all registers, `active_right`, `out_weight_below`, `out_sum`, all valids, `w_ready`, and `w_overrun` are 0; FSM EMPTY.
- Reset mid-load or mid-compute discards everything, including `active_w`.
- Latency with `w_compute` held high: input at edge t reaches `out_sum[c]`/`out_sum_valid[c]` after edge t+c and reaches `active_right` after edge t+N-1, i.e. column c lags by c+1 cycles.
- Stall cycles add exactly one cycle each to every in-flight item.
- `w_ready` rises the cycle after the `w_tile_row_size`-th `w_en`.
- New `active_w` is used from the first compute edge after the swap edge.

## Test plan
- Reset with all inputs nonzero → every output 0; release, idle 5 cycles → outputs stay 0.
- dw=8, N=4, rows=2: load W=[1,2,3,4] then swap; drive `active_left`=5 for one cycle with `in_sum`=0 → `out_sum`=5,10,15,20 at lags 1,2,3,4; `active_right`=5 at lag 4.
- Preload shadow [7,7,7,7] while streaming activations against [1,2,3,4]; swap in the same cycle as `w_en` → products switch cleanly at the swap boundary; `w_ready` drops; FSM LOADING with count 1.
- 3 `w_en` with rows=2 → `w_overrun`=1 and stays set until a swap; `w_swap` while count=1 → ignored, `active_w` unchanged.
- Stall: `w_compute`=0 for 3 cycles mid-stream → all outputs frozen; results delayed by exactly 3 cycles, none lost or duplicated.
- `saturate`=1, acc_width=16: `in_sum`=32000, A=127, W=127 → 32767; with `saturate`=0 → wrapped value (48129 mod 2^16 = -17407).

Source files
------------

// File: rtl/pe_row_db.sv
// Double-buffered weight-stationary systolic PE row: shadow weights load through
// the vertical chain while active weights compute; a one-cycle swap promotes them.
module pe_row_db #(
  parameter int unsigned data_width         = 22,
  parameter int unsigned w_tile_column_size = 11,
  parameter int unsigned w_tile_row_size    = 11,
  parameter int unsigned acc_width          = 2*data_width,
  parameter bit          saturate           = 1'b0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     w_en,
  input  logic                                     w_swap,
  input  logic                                     w_compute,
  output logic                                     w_ready,
  output logic                                     w_overrun,
  input  logic                                     act_valid_left,
  input  logic [data_width-1:0]                    active_left,
  output logic                                     act_valid_right,
  output logic [data_width-1:0]                    active_right,
  input  logic [data_width*w_tile_column_size-1:0] in_weight_above,
  output logic [data_width*w_tile_column_size-1:0] out_weight_below,
  input  logic [acc_width*w_tile_column_size-1:0]  in_sum,
  output logic [acc_width*w_tile_column_size-1:0]  out_sum,
  output logic [w_tile_column_size-1:0]            out_sum_valid
);

  localparam int unsigned DW = data_width;
  localparam int unsigned N  = w_tile_column_size;
  localparam int unsigned AW = acc_width;
  localparam int unsigned PW = 2*data_width;
  localparam int unsigned SW = acc_width + 1;
  localparam int unsigned CW = $clog2(w_tile_row_size + 1);
  localparam logic [CW-1:0] ROWS = CW'(w_tile_row_size);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} load_state_t;

  load_state_t   state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          overrun, overrun_nx;
  logic          swap_ok;

  logic [DW-1:0] shadow_w [N];
  logic [DW-1:0] active_w [N];

  logic [DW-1:0]        a_reg  [N];
  logic [DW-1:0]        a_in   [N];
  logic [N-1:0]         v_reg;
  logic [N-1:0]         v_in;
  logic [AW-1:0]        s_reg  [N];
  logic [AW-1:0]        s_nx   [N];
  logic signed [PW-1:0] prod   [N];
  logic signed [SW-1:0] sum_full [N];

  // Load tracker; a swap with a concurrent w_en starts the next tile at count 1
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    overrun_nx = overrun;
    swap_ok    = w_swap && (state == FULL);
    if (swap_ok) begin
      overrun_nx = 1'b0;
      if (w_en) begin
        count_nx = CW'(1);
        state_nx = (ROWS == CW'(1)) ? FULL : LOADING;
      end else begin
        count_nx = '0;
        state_nx = EMPTY;
      end
    end else if (w_en) begin
      unique case (state)
        EMPTY, LOADING: begin
          count_nx = count + CW'(1);
          state_nx = (count + CW'(1) == ROWS) ? FULL : LOADING;
        end
        FULL:    overrun_nx = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      overrun <= overrun_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < N; c++) begin
        shadow_w[c] <= '0;
        active_w[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N; c++) begin
        if (w_en)    shadow_w[c] <= in_weight_above[c*DW +: DW];
        if (swap_ok) active_w[c] <= shadow_w[c];
      end
    end
  end

  // Product is sign-extended, then added one bit wide so overflow is visible
  always_comb begin
    v_in    = '0;
    a_in[0] = active_left;
    v_in[0] = act_valid_left;
    for (int unsigned c = 1; c < N; c++) begin
      a_in[c] = a_reg[c-1];
      v_in[c] = v_reg[c-1];
    end
    for (int unsigned c = 0; c < N; c++) begin
      prod[c]     = PW'($signed(a_in[c])) * PW'($signed(active_w[c]));
      sum_full[c] = SW'($signed(in_sum[c*AW +: AW])) + SW'(prod[c]);
      if (saturate && (sum_full[c][SW-1] != sum_full[c][SW-2]))
        s_nx[c] = sum_full[c][SW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      else
        s_nx[c] = sum_full[c][AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= '0;
      for (int unsigned c = 0; c < N; c++) begin
        a_reg[c] <= '0;
        s_reg[c] <= '0;
      end
    end else if (w_compute) begin
      v_reg <= v_in;
      for (int unsigned c = 0; c < N; c++) begin
        a_reg[c] <= a_in[c];
        s_reg[c] <= s_nx[c];
      end
    end
  end

  always_comb begin
    out_weight_below = '0;
    out_sum          = '0;
    for (int unsigned c = 0; c < N; c++) begin
      out_weight_below[c*DW +: DW] = shadow_w[c];
      out_sum[c*AW +: AW]          = s_reg[c];
    end
  end

  assign active_right    = a_reg[N-1];
  assign act_valid_right = v_reg[N-1];
  assign out_sum_valid   = v_reg;
  assign w_ready         = (state == FULL);
  assign w_overrun       = overrun;

endmodule

// File: tb/tb_pe_row_db.sv
// Directed bench for pe_row_db: 4-column row, 8-bit data, 16-bit sums,
// with a wrapping and a saturating instance sharing the same stimulus.
module tb_pe_row_db;

  localparam int unsigned DW   = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned ROWS = 2;
  localparam int unsigned AW   = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic w_en, w_swap, w_compute, act_valid_left;
  logic [DW-1:0]   active_left;
  logic [DW*N-1:0] in_weight_above;
  logic [AW*N-1:0] in_sum;

  logic            w_ready, w_overrun, act_valid_right;
  logic [DW-1:0]   active_right;
  logic [DW*N-1:0] out_weight_below;
  logic [AW*N-1:0] out_sum;
  logic [N-1:0]    out_sum_valid;

  logic            s_w_ready, s_w_overrun, s_act_valid_right;
  logic [DW-1:0]   s_active_right;
  logic [DW*N-1:0] s_out_weight_below;
  logic [AW*N-1:0] s_out_sum;
  logic [N-1:0]    s_out_sum_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_row_db #(.data_width(DW), .w_tile_column_size(N), .w_tile_row_size(ROWS),
              .acc_width(AW), .saturate(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_swap(w_swap), .w_compute(w_compute),
    .w_ready(w_ready), .w_overrun(w_overrun), .act_valid_left(act_valid_left),
    .active_left(active_left), .act_valid_right(act_valid_right),
    .active_right(active_right), .in_weight_above(in_weight_above),
    .out_weight_below(out_weight_below), .in_sum(in_sum), .out_sum(out_sum),
    .out_sum_valid(out_sum_valid)
  );

  pe_row_db #(.data_width(DW), .w_tile_column_size(N), .w_tile_row_size(ROWS),
              .acc_width(AW), .saturate(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_swap(w_swap), .w_compute(w_compute),
    .w_ready(s_w_ready), .w_overrun(s_w_overrun), .act_valid_left(act_valid_left),
    .active_left(active_left), .act_valid_right(s_act_valid_right),
    .active_right(s_active_right), .in_weight_above(in_weight_above),
    .out_weight_below(s_out_weight_below), .in_sum(in_sum), .out_sum(s_out_sum),
    .out_sum_valid(s_out_sum_valid)
  );

  function automatic logic [DW*N-1:0] pw(input int c0, input int c1, input int c2, input int c3);
    return {DW'(c3), DW'(c2), DW'(c1), DW'(c0)};
  endfunction

  function automatic logic [AW*N-1:0] ps(input int c0, input int c1, input int c2, input int c3);
    return {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held with every input active
    rst_n = 1'b0; w_en = 1'b1; w_swap = 1'b1; w_compute = 1'b1;
    act_valid_left = 1'b1; active_left = 8'h5a; in_weight_above = '1; in_sum = '1;
    repeat (3) tick;
    chk("rst_active_right", 64'(active_right), 64'(0));
    chk("rst_valid_right", 64'(act_valid_right), 64'(0));
    chk("rst_weight_below", 64'(out_weight_below), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_sum_valid", 64'(out_sum_valid), 64'(0));
    chk("rst_ready", 64'(w_ready), 64'(0));
    chk("rst_overrun", 64'(w_overrun), 64'(0));
    chk("rst_sat_out_sum", 64'(s_out_sum), 64'(0));

    w_en = 1'b0; w_swap = 1'b0; act_valid_left = 1'b0; active_left = '0;
    in_weight_above = '0; in_sum = '0;
    rst_n = 1'b1;
    repeat (5) tick;
    chk("idle_out_sum", 64'(out_sum), 64'(0));
    chk("idle_weight_below", 64'(out_weight_below), 64'(0));
    chk("idle_flags", 64'({w_ready, w_overrun, act_valid_right, out_sum_valid}), 64'(0));
    chk("idle_active_right", 64'(active_right), 64'(0));

    // load [1,2,3,4] behind a dummy row, then swap
    w_en = 1'b1; in_weight_above = pw(9, 9, 9, 9);
    tick;
    chk("load1_ready", 64'(w_ready), 64'(0));
    in_weight_above = pw(1, 2, 3, 4);
    tick;
    w_en = 1'b0;
    chk("load2_ready", 64'(w_ready), 64'(1));
    chk("load2_weight_below", 64'(out_weight_below), 64'(pw(1, 2, 3, 4)));
    w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
    chk("swap_ready_drop", 64'(w_ready), 64'(0));

    // single activation 5 ripples across
    active_left = 8'd5; act_valid_left = 1'b1;
    tick;
    active_left = '0; act_valid_left = 1'b0;
    chk("lag1_sum", 64'(out_sum), 64'(ps(5, 0, 0, 0)));
    chk("lag1_valid", 64'(out_sum_valid), 64'(4'b0001));
    tick;
    chk("lag2_sum", 64'(out_sum), 64'(ps(0, 10, 0, 0)));
    chk("lag2_valid", 64'(out_sum_valid), 64'(4'b0010));
    tick;
    chk("lag3_sum", 64'(out_sum), 64'(ps(0, 0, 15, 0)));
    chk("lag3_valid", 64'(out_sum_valid), 64'(4'b0100));
    tick;
    chk("lag4_sum", 64'(out_sum), 64'(ps(0, 0, 0, 20)));
    chk("lag4_valid", 64'(out_sum_valid), 64'(4'b1000));
    chk("lag4_active_right", 64'(active_right), 64'(5));
    chk("lag4_valid_right", 64'(act_valid_right), 64'(1));
    tick;
    chk("lag5_sum", 64'(out_sum), 64'(0));
    chk("lag5_active_right", 64'(active_right), 64'(0));

    // preload 7s while streaming 1,2,3,4; swap together with w_en
    w_en = 1'b1; in_weight_above = pw(7, 7, 7, 7); active_left = 8'd1; act_valid_left = 1'b1;
    tick;
    chk("pre_a_sum", 64'(out_sum), 64'(ps(1, 0, 0, 0)));
    chk("pre_a_ready", 64'(w_ready), 64'(0));
    active_left = 8'd2;
    tick;
    chk("pre_b_sum", 64'(out_sum), 64'(ps(2, 2, 0, 0)));
    chk("pre_b_ready", 64'(w_ready), 64'(1));
    w_swap = 1'b1; in_weight_above = pw(3, 3, 3, 3); active_left = 8'd3;
    tick;
    chk("swap_edge_sum", 64'(out_sum), 64'(ps(3, 4, 3, 0)));
    chk("swap_edge_ready", 64'(w_ready), 64'(0));
    w_swap = 1'b0; w_en = 1'b0; active_left = 8'd4;
    tick;
    chk("post_swap_sum", 64'(out_sum), 64'(ps(28, 21, 14, 7)));
    chk("post_swap_valid", 64'(out_sum_valid), 64'(4'b1111));

    // swap at count 1 must be ignored
    active_left = '0; act_valid_left = 1'b0; w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
    chk("early_swap_ready", 64'(w_ready), 64'(0));
    chk("early_swap_sum", 64'(out_sum), 64'(ps(0, 28, 21, 14)));
    chk("early_swap_valid", 64'(out_sum_valid), 64'(4'b1110));
    active_left = 8'd1; act_valid_left = 1'b1;
    tick;
    chk("weights_kept_sum", 64'(out_sum), 64'(ps(7, 0, 28, 21)));
    chk("weights_kept_valid", 64'(out_sum_valid), 64'(4'b1101));
    active_left = '0; act_valid_left = 1'b0;
    tick;
    chk("gap_sum", 64'(out_sum), 64'(ps(0, 7, 0, 28)));
    chk("gap_valid", 64'(out_sum_valid), 64'(4'b1010));
    chk("gap_active_right", 64'(active_right), 64'(4));
    chk("gap_valid_right", 64'(act_valid_right), 64'(1));

    // second w_en completes the tile begun at the swap; third overruns
    w_en = 1'b1; in_weight_above = pw(1, 1, 1, 1);
    tick;
    chk("refill_ready", 64'(w_ready), 64'(1));
    chk("refill_overrun", 64'(w_overrun), 64'(0));
    in_weight_above = pw(127, 2, 2, 2);
    tick;
    w_en = 1'b0;
    chk("overrun_set", 64'(w_overrun), 64'(1));
    chk("overrun_ready", 64'(w_ready), 64'(1));
    chk("overrun_shifted", 64'(out_weight_below), 64'(pw(127, 2, 2, 2)));
    tick;
    chk("overrun_sticky", 64'(w_overrun), 64'(1));
    w_swap = 1'b1;
    tick;
    w_swap = 1'b0;
    chk("overrun_cleared", 64'(w_overrun), 64'(0));
    chk("swap2_ready", 64'(w_ready), 64'(0));

    // stall three cycles mid-stream against weights [127,2,2,2]
    active_left = 8'd1; act_valid_left = 1'b1;
    tick;
    chk("stall_s1_sum", 64'(out_sum), 64'(ps(127, 0, 0, 0)));
    active_left = 8'd2;
    tick;
    chk("stall_s2_sum", 64'(out_sum), 64'(ps(254, 2, 0, 0)));
    chk("stall_s2_valid", 64'(out_sum_valid), 64'(4'b0011));
    w_compute = 1'b0; active_left = 8'd99; in_sum = ps(1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_hold_sum", 64'(out_sum), 64'(ps(254, 2, 0, 0)));
      chk("stall_hold_valid", 64'(out_sum_valid), 64'(4'b0011));
    end
    w_compute = 1'b1; active_left = '0; act_valid_left = 1'b0; in_sum = '0;
    tick;
    chk("resume1_sum", 64'(out_sum), 64'(ps(0, 4, 2, 0)));
    chk("resume1_valid", 64'(out_sum_valid), 64'(4'b0110));
    tick;
    chk("resume2_sum", 64'(out_sum), 64'(ps(0, 0, 4, 2)));
    chk("resume2_active_right", 64'(active_right), 64'(1));
    tick;
    chk("resume3_sum", 64'(out_sum), 64'(ps(0, 0, 0, 4)));
    chk("resume3_active_right", 64'(active_right), 64'(2));
    chk("resume3_valid_right", 64'(act_valid_right), 64'(1));
    tick;
    chk("resume4_sum", 64'(out_sum), 64'(0));
    chk("resume4_valid", 64'(out_sum_valid), 64'(0));

    // wrap vs saturate at both ends of the 16-bit range
    active_left = 8'd127; act_valid_left = 1'b1; in_sum = ps(32000, 0, 0, 0);
    tick;
    chk("pos_wrap", 64'(out_sum[AW-1:0]), 64'(16'hBC01));
    chk("pos_sat", 64'(s_out_sum[AW-1:0]), 64'(16'h7FFF));
    active_left = 8'h80; in_sum = ps(-32000, 0, 0, 0);
    tick;
    chk("neg_wrap", 64'(out_sum[AW-1:0]), 64'(16'h4380));
    chk("neg_sat", 64'(s_out_sum[AW-1:0]), 64'(16'h8000));
    active_left = 8'd1; in_sum = ps(100, 0, 0, 0);
    tick;
    chk("nosat_wrap", 64'(out_sum[AW-1:0]), 64'(227));
    chk("nosat_sat", 64'(s_out_sum[AW-1:0]), 64'(227));

    // reset mid-stream discards active weights too
    active_left = 8'd5; in_sum = '0; w_en = 1'b1;
    tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_sum", 64'(out_sum), 64'(0));
    chk("midrst_flags", 64'({w_ready, w_overrun, act_valid_right, out_sum_valid}), 64'(0));
    chk("midrst_weight_below", 64'(out_weight_below), 64'(0));
    tick;
    rst_n = 1'b1; w_en = 1'b0;
    tick;
    chk("postrst_sum", 64'(out_sum), 64'(0));
    chk("postrst_valid", 64'(out_sum_valid), 64'(4'b0001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
